// File: rtl/fractal_iter_stage.sv
// One escape-time fractal iteration z' = f(z) + c (standard / Burning Ship / Tricorn),
// fully pipelined with no stall: S0 fold reg, MUL_PIPELINE_DEPTH product regs, output reg.
module fractal_iter_stage #(
  parameter int DATA_WIDTH         = 32,
  parameter int FRAC_WIDTH         = 28,
  parameter int MUL_PIPELINE_DEPTH = 7,
  parameter int ITER_WIDTH         = 8,
  parameter int ESCAPE_SQ          = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         inc_enabled,
  input  logic [ITER_WIDTH-1:0]        max_iter,
  input  logic                         in_valid,
  input  logic [1:0]                   mode_in,
  input  logic signed [DATA_WIDTH-1:0] zr_in,
  input  logic signed [DATA_WIDTH-1:0] zi_in,
  input  logic signed [DATA_WIDTH-1:0] cr_in,
  input  logic signed [DATA_WIDTH-1:0] ci_in,
  input  logic [ITER_WIDTH-1:0]        iter_in,
  input  logic                         finished_in,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] zr_out,
  output logic signed [DATA_WIDTH-1:0] zi_out,
  output logic [ITER_WIDTH-1:0]        iter_out,
  output logic                         finished_out,
  output logic                         escaped_out
);
  localparam int D  = MUL_PIPELINE_DEPTH;
  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [PW:0] ESC_TH = (PW+1)'(ESCAPE_SQ) << (2 * FRAC_WIDTH);

  typedef struct packed {
    logic [1:0]            mode;
    logic                  live;
    logic                  finished;
    logic                  inc;
    logic [ITER_WIDTH-1:0] iter;
    logic [ITER_WIDTH-1:0] max_iter;
    logic signed [DW-1:0]  zr;
    logic signed [DW-1:0]  zi;
    logic signed [DW-1:0]  cr;
    logic signed [DW-1:0]  ci;
  } side_t;

  typedef struct packed {
    logic signed [PW-1:0] rr;
    logic signed [PW-1:0] ii;
    logic signed [PW-1:0] ri;
  } prod_t;

  function automatic logic signed [DW-1:0] sat_abs(input logic signed [DW-1:0] v);
    logic signed [DW-1:0] r;
    if (v == {1'b1, {(DW-1){1'b0}}}) r = {1'b0, {(DW-1){1'b1}}};
    else if (v < 0)                  r = -v;
    else                             r = v;
    return r;
  endfunction

  logic [D:0]           vld_pipe;
  side_t [D:0]          side_q;
  prod_t [D:1]          prod_q;
  side_t                side_in;
  prod_t                prod_c;
  logic signed [DW-1:0] fr_q, fi_q;
  logic                 fold;

  // Raw z rides in the sideband so finished items leave with z untouched by the fold.
  always_comb begin
    side_in          = '0;
    side_in.mode     = mode_in;
    side_in.live     = in_valid & ~finished_in;
    side_in.finished = finished_in;
    side_in.inc      = inc_enabled;
    side_in.iter     = iter_in;
    side_in.max_iter = max_iter;
    side_in.zr       = zr_in;
    side_in.zi       = zi_in;
    side_in.cr       = cr_in;
    side_in.ci       = ci_in;
  end

  assign fold = (mode_in == 2'd1);

  always_comb begin
    prod_c    = '0;
    prod_c.rr = PW'(fr_q) * PW'(fr_q);
    prod_c.ii = PW'(fi_q) * PW'(fi_q);
    prod_c.ri = PW'(fr_q) * PW'(fi_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      side_q   <= '0;
      prod_q   <= '0;
      fr_q     <= '0;
      fi_q     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[D-1:0], in_valid};
      side_q   <= {side_q[D-1:0], side_in};
      fr_q     <= fold ? sat_abs(zr_in) : zr_in;
      fi_q     <= fold ? sat_abs(zi_in) : zi_in;
      prod_q[1] <= prod_c;
      for (int k = D; k > 1; k--) prod_q[k] <= prod_q[k-1];
    end
  end

  side_t                  s;
  logic signed [PW-1:0]   rr, ii, ri;
  logic signed [PW+1:0]   re_w, im_w;
  logic signed [DW-1:0]   zr_n, zi_n;
  logic [PW:0]            mag;
  logic                   esc;
  logic [ITER_WIDTH-1:0]  iter_n;
  logic                   fin_n;

  assign s  = side_q[D];
  assign rr = prod_q[D].rr;
  assign ii = prod_q[D].ii;
  assign ri = prod_q[D].ri;

  always_comb begin
    re_w = (PW+2)'(rr) - (PW+2)'(ii);
    im_w = (PW+2)'(ri) <<< 1;
    if (s.mode == 2'd2) im_w = -im_w;
    zr_n = DW'(re_w >>> FRAC_WIDTH) + s.cr;
    zi_n = DW'(im_w >>> FRAC_WIDTH) + s.ci;
    // Squares are non-negative, so the sum is safe as an unsigned PW+1 value.
    mag    = {1'b0, rr} + {1'b0, ii};
    esc    = mag > ESC_TH;
    iter_n = (s.live & s.inc & (s.iter < s.max_iter)) ? s.iter + ITER_WIDTH'(1) : s.iter;
    fin_n  = s.finished | (iter_n >= s.max_iter) | (s.live & esc);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid    <= 1'b0;
      zr_out       <= '0;
      zi_out       <= '0;
      iter_out     <= '0;
      finished_out <= 1'b0;
      escaped_out  <= 1'b0;
    end else begin
      out_valid    <= vld_pipe[D];
      zr_out       <= s.live ? zr_n : s.zr;
      zi_out       <= s.live ? zi_n : s.zi;
      iter_out     <= iter_n;
      finished_out <= vld_pipe[D] & fin_n;
      escaped_out  <= vld_pipe[D] & s.live & esc;
    end
  end
endmodule

// File: tb/tb_fractal_iter_stage.sv
// Bench for fractal_iter_stage: directed corner items plus a random stream, scored against
// a wide-integer reference model through a fixed-latency expectation queue.
module tb_fractal_iter_stage;
  localparam int DW = 32;
  localparam int FW = 28;
  localparam int MD = 7;
  localparam int IW = 8;
  localparam int L  = MD + 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          inc_enabled = 1'b1;
  logic [IW-1:0] max_iter = '0;
  logic          in_valid = 1'b0;
  logic [1:0]    mode_in = '0;
  logic [DW-1:0] zr_in = '0, zi_in = '0, cr_in = '0, ci_in = '0;
  logic [IW-1:0] iter_in = '0;
  logic          finished_in = 1'b0;
  logic          out_valid;
  logic [DW-1:0] zr_out, zi_out;
  logic [IW-1:0] iter_out;
  logic          finished_out, escaped_out;

  fractal_iter_stage dut (
    .clk(clk), .resetn(resetn), .inc_enabled(inc_enabled), .max_iter(max_iter),
    .in_valid(in_valid), .mode_in(mode_in), .zr_in(zr_in), .zi_in(zi_in),
    .cr_in(cr_in), .ci_in(ci_in), .iter_in(iter_in), .finished_in(finished_in),
    .out_valid(out_valid), .zr_out(zr_out), .zi_out(zi_out), .iter_out(iter_out),
    .finished_out(finished_out), .escaped_out(escaped_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            v;
    logic [DW-1:0] zr, zi;
    logic [IW-1:0] it;
    bit            fin, esc;
    string         tag;
  } exp_t;

  exp_t  q[$];
  int    n_chk = 0, n_fail = 0;
  bit    dir_on = 0;
  exp_t  dir_e;
  string cur_tag = "";

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 128-bit arithmetic on real-valued fixed point.
  function automatic exp_t model();
    exp_t e;
    longint fr, fi;
    logic signed [127:0] a, b, rr, ii, ri, re, im, t1, t2, th;
    bit live, esc;
    logic [IW-1:0] it;
    fr = longint'($signed(zr_in));
    fi = longint'($signed(zi_in));
    if (mode_in == 2'd1) begin
      if (fr < 0) fr = -fr;
      if (fi < 0) fi = -fi;
      if (fr > 64'sd2147483647) fr = 64'sd2147483647;
      if (fi > 64'sd2147483647) fi = 64'sd2147483647;
    end
    a = fr; b = fi;
    rr = a * a; ii = b * b; ri = a * b;
    re = rr - ii;
    im = ri * 2;
    if (mode_in == 2'd2) im = -im;
    t1 = re >>> FW;
    t2 = im >>> FW;
    th = 128'sd4 <<< (2 * FW);
    esc  = (rr + ii) > th;
    live = in_valid && !finished_in;
    it   = (live && inc_enabled && iter_in < max_iter) ? iter_in + 8'd1 : iter_in;
    e.v   = in_valid;
    e.zr  = live ? t1[DW-1:0] + cr_in : zr_in;
    e.zi  = live ? t2[DW-1:0] + ci_in : zi_in;
    e.it  = it;
    e.fin = in_valid && (finished_in || it >= max_iter || (live && esc));
    e.esc = live && esc;
    e.tag = "";
    return e;
  endfunction

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    if (resetn) begin
      e = dir_on ? dir_e : model();
      e.tag = cur_tag;
      q.push_back(e);
    end
    dir_on = 0;
    @(negedge clk);
    if (q.size() == L) begin
      e = q.pop_front();
      chk({e.tag, ".vld"}, out_valid, e.v);
      chk({e.tag, ".fin"}, finished_out, e.fin);
      chk({e.tag, ".esc"}, escaped_out, e.esc);
      if (e.v) begin
        chk({e.tag, ".zr"}, zr_out, e.zr);
        chk({e.tag, ".zi"}, zi_out, e.zi);
        chk({e.tag, ".iter"}, iter_out, e.it);
      end
    end
  endtask

  task automatic set_item(input logic [1:0] m, input logic [DW-1:0] zr, zi, cr, ci,
                          input logic [IW-1:0] it, mx, input logic fin);
    in_valid = 1'b1; mode_in = m; zr_in = zr; zi_in = zi; cr_in = cr; ci_in = ci;
    iter_in = it; max_iter = mx; finished_in = fin;
  endtask

  task automatic dir(input string tag, input logic [1:0] m, input logic [DW-1:0] zr, zi, cr, ci,
                     input logic [IW-1:0] it, mx, input logic fin,
                     input logic [DW-1:0] ezr, ezi, input logic [IW-1:0] eit,
                     input bit efin, eesc);
    set_item(m, zr, zi, cr, ci, it, mx, fin);
    dir_e.v = 1; dir_e.zr = ezr; dir_e.zi = ezi; dir_e.it = eit;
    dir_e.fin = efin; dir_e.esc = eesc;
    dir_on = 1; cur_tag = tag;
    cycle();
  endtask

  task automatic bubble();
    in_valid = 1'b0; finished_in = 1'(($urandom) & 1); zr_in = $urandom; zi_in = $urandom;
    cur_tag = "bubble";
    cycle();
  endtask

  function automatic logic [DW-1:0] rand_val();
    logic [DW-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = $urandom;
      1:       v = 32'h8000_0000;
      default: v = 32'($urandom_range(0, 32'h4000_0000)) - 32'h2000_0000;
    endcase
    return v;
  endfunction

  task automatic rand_item(input bit vld);
    in_valid    = vld;
    mode_in     = 2'($urandom_range(0, 3));
    zr_in       = rand_val();
    zi_in       = rand_val();
    cr_in       = 32'($urandom_range(0, 32'h2000_0000)) - 32'h1000_0000;
    ci_in       = 32'($urandom_range(0, 32'h2000_0000)) - 32'h1000_0000;
    iter_in     = 8'($urandom_range(0, 255));
    max_iter    = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
    finished_in = ($urandom_range(0, 7) == 0);
    cur_tag     = "rand";
    cycle();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.vld", out_valid, 0);
    chk("rst.zr", zr_out, 0);
    chk("rst.zi", zi_out, 0);
    chk("rst.iter", iter_out, 0);
    chk("rst.fin", finished_out, 0);
    chk("rst.esc", escaped_out, 0);
    resetn = 1'b1;

    dir("t1_mode0", 0, 0, 0, 32'h0400_0000, 0, 0, 255, 0, 32'h0400_0000, 0, 1, 0, 0);
    dir("t2_esc", 0, 32'h1800_0000, 32'h1800_0000, 0, 0, 5, 255, 0, 0, 32'h4800_0000, 6, 1, 1);
    dir("t2_eq4", 0, 32'h2000_0000, 0, 0, 0, 5, 255, 0, 32'h4000_0000, 0, 6, 0, 0);
    bubble();
    dir("t3_m0", 0, 32'hF800_0000, 32'h0800_0000, 0, 0, 0, 255, 0, 0, 32'hF800_0000, 1, 0, 0);
    dir("t3_m1", 1, 32'hF800_0000, 32'h0800_0000, 0, 0, 0, 255, 0, 0, 32'h0800_0000, 1, 0, 0);
    dir("t3_m2", 2, 32'hF800_0000, 32'h0800_0000, 0, 0, 0, 255, 0, 0, 32'h0800_0000, 1, 0, 0);
    dir("t3_m3", 3, 32'hF800_0000, 32'h0800_0000, 0, 0, 0, 255, 0, 0, 32'hF800_0000, 1, 0, 0);
    dir("t4_reach", 0, 32'h0100_0000, 0, 0, 0, 9, 10, 0, 32'h0010_0000, 0, 10, 1, 0);
    dir("t4_sat", 0, 32'h0100_0000, 0, 0, 0, 10, 10, 0, 32'h0010_0000, 0, 10, 1, 0);
    dir("t5_frozen", 0, 32'h1234_5678, 32'h0ABC_DEF0, 32'h0100_0000, 0, 37, 255, 1,
        32'h1234_5678, 32'h0ABC_DEF0, 37, 1, 0);
    dir("max0", 0, 0, 0, 32'h0400_0000, 0, 3, 0, 0, 32'h0400_0000, 0, 3, 1, 0);
    bubble();

    // inc_enabled held low until that item has drained out.
    inc_enabled = 1'b0;
    dir("noinc", 0, 0, 0, 0, 0, 4, 255, 0, 0, 0, 4, 0, 0);
    repeat (L) bubble();
    inc_enabled = 1'b1;

    for (int i = 0; i < 60; i++) rand_item($urandom_range(0, 3) != 0);

    // 1101 stream, reset dropped while items are in flight.
    for (int i = 0; i < 12; i++) rand_item((i % 4) != 2);
    resetn = 1'b0;
    #1;
    chk("mid_rst.vld", out_valid, 0);
    chk("mid_rst.zr", zr_out, 0);
    chk("mid_rst.zi", zi_out, 0);
    chk("mid_rst.iter", iter_out, 0);
    chk("mid_rst.fin", finished_out, 0);
    chk("mid_rst.esc", escaped_out, 0);
    q.delete();
    in_valid = 1'b0;
    repeat (2) cycle();
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) rand_item((i % 4) != 2);
    repeat (L + 1) bubble();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
